// File: rtl/router_out_arbiter.sv
// Output-port arbiter: round-robin grant of three FWFT FIFOs to one downstream link,
// packet framing (header/payload/parity), stall timeout with FIFO flush.
module router_out_arbiter #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  input  logic       ready_out,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       last_out,
  output logic [1:0] grant,
  output logic       busy,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  localparam int unsigned LEN_W   = 6;
  localparam int unsigned STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0]  NO_GRANT = 2'd3;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    PARITY  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic [2:0] req;
  logic [2:0] arb;
  logic [2:0] grant_oh;
  logic [2:0] rd_vec;
  logic [2:0] sr_vec;
  logic       sel_empty;
  logic [7:0] sel_data;
  logic       in_prog;
  logic       xfer;
  logic       timeout;

  // First requester in the order a, b, c; MSB flags that one was found.
  function automatic logic [2:0] pick3(input logic [2:0] r, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] c);
    if (r[a]) return {1'b1, a};
    if (r[b]) return {1'b1, b};
    if (r[c]) return {1'b1, c};
    return {1'b0, NO_GRANT};
  endfunction

  assign req = ~{fifo_empty_2, fifo_empty_1, fifo_empty_0};

  // Round-robin search starting at ptr+1 mod 3.
  always_comb begin
    arb = {1'b0, NO_GRANT};
    case (ptr_q)
      2'd0:    arb = pick3(req, 2'd1, 2'd2, 2'd0);
      2'd1:    arb = pick3(req, 2'd2, 2'd0, 2'd1);
      default: arb = pick3(req, 2'd0, 2'd1, 2'd2);
    endcase
  end

  always_comb begin
    sel_empty = 1'b1;
    sel_data  = 8'h00;
    grant_oh  = 3'b000;
    case (grant_q)
      2'd0: begin sel_empty = fifo_empty_0; sel_data = data_0; grant_oh = 3'b001; end
      2'd1: begin sel_empty = fifo_empty_1; sel_data = data_1; grant_oh = 3'b010; end
      2'd2: begin sel_empty = fifo_empty_2; sel_data = data_2; grant_oh = 3'b100; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= NO_GRANT;
      ptr_q   <= 2'd2;
      len_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      stall_q <= stall_d;
    end
  end

  // Next state plus the combinational datapath driven from the granted FIFO.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    stall_d = stall_q;

    in_prog   = (state_q != IDLE);
    valid_out = in_prog & ~sel_empty;
    xfer      = valid_out & ready_out;
    timeout   = valid_out & ~ready_out & (stall_q == STALL_LAST);
    data_out  = in_prog ? sel_data : 8'h00;
    last_out  = (state_q == PARITY) & valid_out;
    rd_vec    = {3{xfer & ~timeout}} & grant_oh;
    sr_vec    = {3{timeout}} & grant_oh;
    busy      = in_prog;
    grant     = grant_q;

    case (state_q)
      IDLE: begin
        stall_d = '0;
        grant_d = NO_GRANT;
        if (arb[2]) begin
          grant_d = arb[1:0];
          ptr_d   = arb[1:0];
          state_d = HEADER;
        end
      end
      default: begin
        if (timeout) begin
          state_d = IDLE;
          grant_d = NO_GRANT;
          stall_d = '0;
        end else if (xfer) begin
          stall_d = '0;
          case (state_q)
            HEADER: begin
              len_d   = sel_data[7:2];
              state_d = (sel_data[7:2] != '0) ? PAYLOAD : PARITY;
            end
            PAYLOAD: begin
              len_d = len_q - LEN_W'(1);
              if (len_q == LEN_W'(1)) state_d = PARITY;
            end
            default: begin
              state_d = IDLE;
              grant_d = NO_GRANT;
            end
          endcase
        end else if (valid_out) begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
    endcase

    read_enb_0   = rd_vec[0];
    read_enb_1   = rd_vec[1];
    read_enb_2   = rd_vec[2];
    soft_reset_0 = sr_vec[0];
    soft_reset_1 = sr_vec[1];
    soft_reset_2 = sr_vec[2];
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: FWFT FIFO models feed the DUT and a
// scoreboard of expected (port, byte, last) transfers is checked at each handshake.
module tb_router_out_arbiter;

  logic       clock;
  logic       resetn;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic [7:0] data_0, data_1, data_2;
  logic       ready_out;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] data_out;
  logic       valid_out, last_out, busy;
  logic [1:0] grant;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  router_out_arbiter #(.TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .data_0(data_0), .data_1(data_1), .data_2(data_2),
    .ready_out(ready_out),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .data_out(data_out), .valid_out(valid_out), .last_out(last_out),
    .grant(grant), .busy(busy),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
  );

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fq0[$], fq1[$], fq2[$];
  logic [2:0] hide;
  int         vectors, miscompares;

  logic       s_valid, s_ready, s_last, s_busy;
  logic [1:0] s_grant;
  logic [7:0] s_data;
  logic [2:0] s_rd, s_sr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty_0 = hide[0] || (fq0.size() == 0);
    fifo_empty_1 = hide[1] || (fq1.size() == 0);
    fifo_empty_2 = hide[2] || (fq2.size() == 0);
    data_0 = (fq0.size() != 0) ? fq0[0] : 8'h00;
    data_1 = (fq1.size() != 0) ? fq1[0] : 8'h00;
    data_2 = (fq2.size() != 0) ? fq2[0] : 8'h00;
  endtask

  task automatic push_byte(input int port, input logic [7:0] b);
    case (port)
      0: fq0.push_back(b);
      1: fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
  endtask

  // Queue a packet into FIFO 'port'; the first n_exp bytes are expected on the output.
  task automatic load_pkt(input int port, input int len, input int n_exp);
    logic [7:0] b;
    logic [7:0] par;
    exp_t e;
    par = 8'h00;
    for (int i = 0; i < len + 2; i++) begin
      if (i == 0) b = {6'(len), 2'(port)};
      else if (i == len + 1) b = par;
      else b = 8'($urandom);
      if (i <= len) par = par ^ b;
      push_byte(port, b);
      if (i < n_exp) begin
        e.port = 2'(port);
        e.data = b;
        e.last = (i == len + 1);
        exp_q.push_back(e);
      end
    end
    refresh();
  endtask

  // One clock: sample at negedge, score any handshake, then apply pops/flushes after the edge.
  task automatic step();
    exp_t e;
    @(negedge clock);
    s_valid = valid_out; s_ready = ready_out; s_last = last_out;
    s_grant = grant; s_busy = busy; s_data = data_out;
    s_rd = {read_enb_2, read_enb_1, read_enb_0};
    s_sr = {soft_reset_2, soft_reset_1, soft_reset_0};
    if (s_valid && s_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", 32'(s_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("xfer_grant", 32'(s_grant), 32'(e.port));
        check("xfer_data", 32'(s_data), 32'(e.data));
        check("xfer_last", 32'(s_last), 32'(e.last));
        check("xfer_rd", 32'(s_rd), 32'(1) << e.port);
      end
    end else begin
      check("rd_quiet", 32'(s_rd), 32'(0));
    end
    @(posedge clock);
    #1;
    if (s_rd[0] && fq0.size() != 0) void'(fq0.pop_front());
    if (s_rd[1] && fq1.size() != 0) void'(fq1.pop_front());
    if (s_rd[2] && fq2.size() != 0) void'(fq2.pop_front());
    if (s_sr[0]) fq0.delete();
    if (s_sr[1]) fq1.delete();
    if (s_sr[2]) fq2.delete();
    refresh();
  endtask

  task automatic drain(input int bound, input bit stop_on_last, output int n, output int cyc);
    bit done;
    n = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < bound) begin
      step();
      cyc++;
      if (s_valid && s_ready) begin
        n++;
        if (s_last && stop_on_last) done = 1'b1;
      end
      if (exp_q.size() == 0) done = 1'b1;
    end
    check("drain_done", 32'(done), 32'(1));
  endtask

  // Arbitration cycle, grant visible after the edge, then the whole packet back-to-back.
  task automatic run_pkt(input int port, input int exp_n);
    int n, cyc;
    step();
    check("arb_cycle", 32'({s_busy, s_grant}), 32'({1'b0, 2'd3}));
    check("grant_next", 32'(grant), 32'(port));
    drain(200, 1'b1, n, cyc);
    check("pkt_xfers", 32'(n), 32'(exp_n));
    check("pkt_cycles", 32'(cyc), 32'(exp_n));
  endtask

  initial begin
    int n, cyc;
    logic [2:0] sr_early;
    vectors = 0; miscompares = 0;
    hide = 3'b000;
    ready_out = 1'b1;
    resetn = 1'b1;
    refresh();
    #1 resetn = 1'b0;
    #1;
    check("reset_outs", 32'({busy, valid_out, last_out, read_enb_2, read_enb_1, read_enb_0,
                            soft_reset_2, soft_reset_1, soft_reset_0, grant}),
          32'({9'b0, 2'd3}));
    check("reset_data", 32'(data_out), 32'(0));
    step(); step();
    resetn = 1'b1;

    // Single packet on port 1, header 0x0D.
    load_pkt(1, 3, 99);
    check("hdr_0x0d", 32'(data_1), 32'h0D);
    run_pkt(1, 5);
    step();
    check("idle_after", 32'({s_busy, s_valid, s_rd}), 32'(0));

    // Zero-length payload.
    load_pkt(0, 0, 99);
    run_pkt(0, 2);

    // All three ports loaded from reset: order 0,1,2,0.
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    load_pkt(0, 2, 99);
    load_pkt(1, 1, 99);
    load_pkt(2, 3, 99);
    load_pkt(0, 0, 99);
    run_pkt(0, 4);
    run_pkt(1, 3);
    run_pkt(2, 5);
    run_pkt(0, 2);

    // FIFO 0 underflows for 4 cycles mid-payload.
    load_pkt(0, 6, 99);
    step();
    check("uf_grant", 32'(grant), 32'(0));
    step(); step(); step();
    hide = 3'b001;
    refresh();
    for (int i = 0; i < 4; i++) begin
      step();
      check("underflow", 32'({s_valid, s_busy, s_sr}), 32'({1'b0, 1'b1, 3'b000}));
    end
    hide = 3'b000;
    refresh();
    drain(50, 1'b1, n, cyc);
    check("uf_rest_xfers", 32'(n), 32'(5));
    check("uf_rest_cycles", 32'(cyc), 32'(5));

    // Port 2 stalls in payload until timeout.
    load_pkt(2, 5, 2);
    step();
    check("to_grant", 32'(grant), 32'(2));
    step(); step();
    ready_out = 1'b0;
    sr_early = 3'b000;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i < 30) sr_early = sr_early | s_sr;
      else check("timeout_pulse", 32'({s_sr, s_rd, s_busy}), 32'({3'b100, 3'b000, 1'b1}));
    end
    check("no_early_sr", 32'(sr_early), 32'(0));
    ready_out = 1'b1;
    load_pkt(0, 2, 99);
    load_pkt(1, 1, 99);
    step();
    check("post_abort_idle", 32'({s_busy, s_sr, s_grant}), 32'({1'b0, 3'b000, 2'd3}));
    check("search_from_0", 32'(grant), 32'(0));
    drain(300, 1'b0, n, cyc);
    check("post_abort_drain", 32'(exp_q.size()), 32'(0));

    // Asynchronous reset in the middle of a port-1 packet.
    load_pkt(1, 4, 99);
    step();
    check("mid_grant", 32'(grant), 32'(1));
    step(); step();
    check("pre_rst_active", 32'({busy, valid_out}), 32'({1'b1, 1'b1}));
    resetn = 1'b0;
    #2;
    check("rst_async_outs", 32'({busy, valid_out, last_out, read_enb_2, read_enb_1, read_enb_0,
                                soft_reset_2, soft_reset_1, soft_reset_0, grant}),
          32'({9'b0, 2'd3}));
    check("rst_async_data", 32'(data_out), 32'(0));
    fq1.delete();
    exp_q.delete();
    refresh();
    step();
    check("rst_held", 32'({s_busy, s_sr, s_grant}), 32'({1'b0, 3'b000, 2'd3}));
    resetn = 1'b1;
    load_pkt(0, 2, 99);
    load_pkt(2, 1, 99);
    run_pkt(0, 4);
    run_pkt(2, 3);

    check("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
